// File: rtl/radix4_booth_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed/unsigned mode.
// Optional early termination when RADIX4_EARLY_TERM_EN is defined.
module radix4_booth_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    input  logic                 getA,
    input  logic                 getB,
    input  logic                 signed_mode,
    input  logic                 start,
    input  logic                 putOut,
    output logic [2*WIDTH-1:0]   res,
    output logic                 busy,
    output logic                 done
);

    localparam int K  = (WIDTH + 2) / 2;
    localparam int AW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 2;
    localparam int CW = $clog2(K);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("radix4_booth_mult: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       a_reg, b_reg;
    logic signed [AW-1:0]   mcand, acc;
    logic [BW-1:0]          bsh;
    logic                   prev;
    logic [CW-1:0]          cnt;
    logic [2*WIDTH-1:0]     res_reg;
    logic                   idle_or_done, start_acc, last_iter;
    logic signed [AW-1:0]   a_ext;
    logic [BW-1:0]          b_ext;

    // Partial product for one Booth digit recoded from {b[2i+1], b[2i], b[2i-1]}
    function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                      input logic signed [AW-1:0] m);
        logic signed [AW-1:0] pp;
        case (trip)
            3'b001, 3'b010: pp = m;
            3'b011:         pp = m <<< 1;
            3'b100:         pp = -(m <<< 1);
            3'b101, 3'b110: pp = -m;
            default:        pp = '0;
        endcase
        return pp;
    endfunction

    assign idle_or_done = (state != CALC);
    assign start_acc    = idle_or_done && start;
    assign a_ext = {{(WIDTH+2){signed_mode & a_reg[WIDTH-1]}}, a_reg};
    assign b_ext = {{2{signed_mode & b_reg[WIDTH-1]}}, b_reg};

`ifdef RADIX4_EARLY_TERM_EN
    // Remaining multiplier bits (incl. overlap bit) all equal means every later digit is 0
    assign last_iter = (cnt == CW'(K-1)) || (&bsh[BW-1:1]) || !(|bsh[BW-1:1]);
`else
    assign last_iter = (cnt == CW'(K-1));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = CALC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            mcand   <= '0;
            acc     <= '0;
            bsh     <= '0;
            prev    <= 1'b0;
            cnt     <= '0;
            res_reg <= '0;
        end else begin
            if (idle_or_done) begin
                if (getA) a_reg <= in;
                if (getB) b_reg <= in;
            end
            if (state == DONE && putOut) res_reg <= acc[2*WIDTH-1:0];
            if (start_acc) begin
                mcand <= a_ext;
                bsh   <= b_ext;
                prev  <= 1'b0;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                // Multiplicand moves left; accumulator always holds a complete partial sum
                acc   <= acc + booth_pp({bsh[1:0], prev}, mcand);
                mcand <= mcand <<< 2;
                bsh   <= {bsh[BW-1], bsh[BW-1], bsh[BW-1:2]};
                prev  <= bsh[1];
                cnt   <= cnt + CW'(1);
            end
        end
    end

    assign res = res_reg;

endmodule

// File: tb/tb_radix4_booth_mult.sv
// Directed self-checking bench for radix4_booth_mult at WIDTH=8.
module tb_radix4_booth_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in;
    logic        getA, getB, signed_mode, start, putOut;
    logic [15:0] res;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

`ifdef RADIX4_EARLY_TERM_EN
    localparam int LAT_BP  = 2;   // B=0x07
    localparam int LAT_B2B = 4;   // B=0x20
`else
    localparam int LAT_BP  = 5;
    localparam int LAT_B2B = 5;
`endif

    radix4_booth_mult #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in(in), .getA(getA), .getB(getB),
        .signed_mode(signed_mode), .start(start), .putOut(putOut),
        .res(res), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        getA = 1'b1; in = a;
        @(posedge clk); #1;
        getA = 1'b0; getB = 1'b1; in = b;
        @(posedge clk); #1;
        getB = 1'b0;
    endtask

    task automatic run(input logic sm, output int lat);
        signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic put_out;
        putOut = 1'b1;
        @(posedge clk); #1;
        putOut = 1'b0;
    endtask

    task automatic test_reset_state;
        checks++;
        if (res !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: res=%h busy=%b done=%b, expected res=0000 busy=0 done=0", res, busy, done);
        end
    endtask

    task automatic test_unsigned;
        int lat;
        load_ops(8'hFF, 8'hFF);
        run(1'b0, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL unsigned_latency: got %0d, expected 5", lat);
        end
        put_out();
        checks++;
        if (res !== 16'hFE01) begin
            errors++;
            $display("FAIL unsigned_ff_ff: res=%h, expected FE01", res);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b busy=%b, expected 1 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_calc;
        load_ops(8'h55, 8'hAA);
        signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_calc: busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (res !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_calc: res=%h busy=%b done=%b, expected 0000 0 0", res, busy, done);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_signed;
        int lat;
        logic [7:0]  av [4] = '{8'hFF, 8'h80, 8'h80, 8'h7F};
        logic [7:0]  bv [4] = '{8'hFF, 8'h80, 8'h7F, 8'hFF};
        logic [15:0] ev [4] = '{16'h0001, 16'h4000, 16'hC080, 16'hFF81};
        for (int i = 0; i < 4; i++) begin
            load_ops(av[i], bv[i]);
            run(1'b1, lat);
            put_out();
            checks++;
            if (res !== ev[i]) begin
                errors++;
                $display("FAIL signed_%0d: %h*%h res=%h, expected %h", i, av[i], bv[i], res, ev[i]);
            end
        end
    endtask

    task automatic test_same_bus_load;
        int lat;
        getA = 1'b1; getB = 1'b1; in = 8'h0D;
        @(posedge clk); #1;
        getA = 1'b0; getB = 1'b0; in = 8'h00;
        run(1'b0, lat);
        put_out();
        checks++;
        if (res !== 16'h00A9) begin
            errors++;
            $display("FAIL same_bus_load: res=%h, expected 00A9", res);
        end
    endtask

    task automatic test_busy_protection;
        int lat;
        logic [15:0] prev_res;
        prev_res = res;
        load_ops(8'h0B, 8'h07);
        signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; getA = 1'b1; putOut = 1'b1; in = 8'h12; signed_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; getA = 1'b0; putOut = 1'b0; in = 8'h00; signed_mode = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== LAT_BP) begin
            errors++;
            $display("FAIL busy_latency: got %0d, expected %0d", lat, LAT_BP);
        end
        checks++;
        if (res !== prev_res) begin
            errors++;
            $display("FAIL putout_in_calc: res=%h, expected %h", res, prev_res);
        end
        put_out();
        checks++;
        if (res !== 16'h004D) begin
            errors++;
            $display("FAIL busy_product: res=%h, expected 004D", res);
        end
        // A must not have been overwritten by the 0x12 pulse
        run(1'b0, lat);
        put_out();
        checks++;
        if (res !== 16'h004D) begin
            errors++;
            $display("FAIL operand_kept: res=%h, expected 004D", res);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        load_ops(8'h06, 8'h09);
        run(1'b0, lat);
        load_ops(8'h10, 8'h20);
        start = 1'b1; putOut = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; putOut = 1'b0;
        checks++;
        if (res !== 16'h0036 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: res=%h busy=%b, expected 0036 1", res, busy);
        end
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== LAT_B2B) begin
            errors++;
            $display("FAIL b2b_latency: got %0d, expected %0d", lat, LAT_B2B);
        end
        checks++;
        if (res !== 16'h0036) begin
            errors++;
            $display("FAIL b2b_res_held: res=%h, expected 0036", res);
        end
        put_out();
        checks++;
        if (res !== 16'h0200) begin
            errors++;
            $display("FAIL b2b_second: res=%h, expected 0200", res);
        end
    endtask

`ifdef RADIX4_EARLY_TERM_EN
    task automatic test_early_term;
        int lat;
        load_ops(8'h03, 8'h05);
        run(1'b0, lat);
        put_out();
        checks++;
        if (lat !== 2 || res !== 16'h000F) begin
            errors++;
            $display("FAIL early_3x5: lat=%0d res=%h, expected 2 000F", lat, res);
        end
        load_ops(8'h03, 8'h80);
        run(1'b0, lat);
        put_out();
        checks++;
        if (lat !== 5 || res !== 16'h0180) begin
            errors++;
            $display("FAIL early_3x80: lat=%0d res=%h, expected 5 0180", lat, res);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in = '0; getA = 1'b0; getB = 1'b0;
        signed_mode = 1'b0; start = 1'b0; putOut = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset_state();
        rst = 1'b0;
        test_unsigned();
        test_reset_mid_calc();
        test_signed();
        test_same_bus_load();
        test_busy_protection();
        test_back_to_back();
`ifdef RADIX4_EARLY_TERM_EN
        test_early_term();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
